// File: rtl/except_ctrl_if.sv
// Bus between the MEM stage / CP0 and the exception controller.
// master = pipeline/CP0 side, slave = except_ctrl.
interface except_ctrl_if;
  logic        valid_i;
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;
  logic [4:0]  exc_i;
  logic [5:0]  int_i;
  logic        timer_int_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic [31:0] except_type_o;
  logic [31:0] pc_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic        stall_req_o;
  logic        redirect_valid_o;
  logic [31:0] new_pc_o;
  logic        redirect_ready_i;

  modport master (
    output valid_i, pc_i, is_in_delayslot_i, exc_i, int_i, timer_int_i,
           status_i, cause_i, epc_i, redirect_ready_i,
    input  except_type_o, pc_o, is_in_delayslot_o, flush_o, stall_req_o,
           redirect_valid_o, new_pc_o
  );

  modport slave (
    input  valid_i, pc_i, is_in_delayslot_i, exc_i, int_i, timer_int_i,
           status_i, cause_i, epc_i, redirect_ready_i,
    output except_type_o, pc_o, is_in_delayslot_o, flush_o, stall_req_o,
           redirect_valid_o, new_pc_o
  );
endinterface

// File: rtl/except_ctrl.sv
// Precise-exception controller: captures one MEM-stage exception/interrupt, flushes, then redirects fetch.
// Optional TIMER_INT_EN: folds the CP0 timer interrupt into IP7.
module except_ctrl (
  input  logic         clk,
  input  logic         rst,
  except_ctrl_if.slave bus
);

  localparam logic [31:0] CODE_NONE  = 32'h0000_0000;
  localparam logic [31:0] CODE_INT   = 32'h0000_0001;
  localparam logic [31:0] CODE_INVAL = 32'h0000_000a;
  localparam logic [31:0] CODE_OV    = 32'h0000_000c;
  localparam logic [31:0] CODE_TRAP  = 32'h0000_000d;
  localparam logic [31:0] CODE_SYS   = 32'h0000_0008;
  localparam logic [31:0] CODE_ERET  = 32'h0000_000e;
  localparam logic [31:0] VEC_BEV    = 32'hBFC0_0380;
  localparam logic [31:0] VEC_NORM   = 32'h8000_0180;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  sync1_q, sync1_d;
  logic [5:0]  sync2_q, sync2_d;
  logic [31:0] except_type_q, except_type_d;
  logic [31:0] pc_q, pc_d;
  logic        slot_q, slot_d;
  logic        flush_q, flush_d;
  logic        stall_q, stall_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] new_pc_q, new_pc_d;

  logic [5:0]  sync_int_s;
  logic        int_pending_s;
  logic        take_s;
  logic [31:0] code_s;
  logic        unused_s;

  // Fixed-priority encoder: interrupt first, then inst_invalid (bit0) up to eret (bit4).
  function automatic logic [31:0] prio_code(input logic pend, input logic [4:0] exc);
    logic [31:0] code;
    if (pend)        code = CODE_INT;
    else if (exc[0]) code = CODE_INVAL;
    else if (exc[1]) code = CODE_OV;
    else if (exc[2]) code = CODE_TRAP;
    else if (exc[3]) code = CODE_SYS;
    else if (exc[4]) code = CODE_ERET;
    else             code = CODE_NONE;
    return code;
  endfunction

  // Synchronised interrupt lines; the timer is already in this clock domain.
  always_comb begin
`ifdef TIMER_INT_EN
    sync_int_s = sync2_q | {bus.timer_int_i, 5'b0_0000};
`else
    sync_int_s = sync2_q;
`endif
    int_pending_s = (|({sync_int_s, bus.cause_i[9:8]} & bus.status_i[15:8]))
                    & bus.status_i[0] & ~bus.status_i[1];
    take_s = bus.valid_i & (int_pending_s | (|bus.exc_i));
    code_s = prio_code(int_pending_s, bus.exc_i);
  end

  // Next-state and next-output logic for the IDLE -> COMMIT -> REDIRECT sequence.
  always_comb begin
    state_d          = state_q;
    sync1_d          = bus.int_i;
    sync2_d          = sync1_q;
    except_type_d    = CODE_NONE;
    flush_d          = 1'b0;
    pc_d             = pc_q;
    slot_d           = slot_q;
    stall_d          = stall_q;
    redirect_valid_d = redirect_valid_q;
    new_pc_d         = new_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          state_d       = ST_COMMIT;
          except_type_d = code_s;
          pc_d          = bus.pc_i;
          slot_d        = bus.is_in_delayslot_i;
          flush_d       = 1'b1;
          stall_d       = 1'b1;
        end else begin
          stall_d          = 1'b0;
          redirect_valid_d = 1'b0;
        end
      end
      ST_COMMIT: begin
        state_d          = ST_REDIRECT;
        redirect_valid_d = 1'b1;
        stall_d          = 1'b1;
        // Target is sampled here so CP0 forwarding of EPC/BEV is settled.
        if (except_type_q == CODE_ERET) begin
          new_pc_d = bus.epc_i;
        end else if (bus.status_i[22]) begin
          new_pc_d = VEC_BEV;
        end else begin
          new_pc_d = VEC_NORM;
        end
      end
      ST_REDIRECT: begin
        if (bus.redirect_ready_i) begin
          state_d          = ST_IDLE;
          redirect_valid_d = 1'b0;
          stall_d          = 1'b0;
        end else begin
          redirect_valid_d = 1'b1;
          stall_d          = 1'b1;
        end
      end
      default: begin
        state_d          = ST_IDLE;
        stall_d          = 1'b0;
        redirect_valid_d = 1'b0;
        new_pc_d         = 32'h0000_0000;
      end
    endcase
  end

  // State, synchroniser and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      sync1_q          <= 6'b00_0000;
      sync2_q          <= 6'b00_0000;
      except_type_q    <= 32'h0000_0000;
      pc_q             <= 32'h0000_0000;
      slot_q           <= 1'b0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      new_pc_q         <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      sync1_q          <= sync1_d;
      sync2_q          <= sync2_d;
      except_type_q    <= except_type_d;
      pc_q             <= pc_d;
      slot_q           <= slot_d;
      flush_q          <= flush_d;
      stall_q          <= stall_d;
      redirect_valid_q <= redirect_valid_d;
      new_pc_q         <= new_pc_d;
    end
  end

  assign bus.except_type_o     = except_type_q;
  assign bus.pc_o              = pc_q;
  assign bus.is_in_delayslot_o = slot_q;
  assign bus.flush_o           = flush_q;
  assign bus.stall_req_o       = stall_q;
  assign bus.redirect_valid_o  = redirect_valid_q;
  assign bus.new_pc_o          = new_pc_q;

`ifdef TIMER_INT_EN
  assign unused_s = ^{bus.status_i[31:23], bus.status_i[21:16], bus.status_i[7:2],
                      bus.cause_i[31:10], bus.cause_i[7:0]};
`else
  assign unused_s = ^{bus.status_i[31:23], bus.status_i[21:16], bus.status_i[7:2],
                      bus.cause_i[31:10], bus.cause_i[7:0], bus.timer_int_i};
`endif

endmodule
